regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default core_pkg::XLEN (32), meaning data width.
REQ-002 SHALL have parameter PREGS, default core_pkg::PREGS (64), meaning the number of physical entries (power of two, at least 4).
REQ-003 SHALL have parameter NUM_WR, default 2, meaning the number of write/wakeup ports.
REQ-004 SHALL have parameter NUM_RD, default 4, meaning the number of combinational read ports.
REQ-005 SHALL have parameter NUM_ALLOC, default 2, meaning the number of allocate (busy-set) ports from rename.
REQ-006 SHALL have ports:
  clk  in  1  single clock, rising edge
  reset_n  in  1  asynchronous, active-low reset
  alloc_valid  in  NUM_ALLOC  allocate strobe per port
  alloc_tag  in  NUM_ALLOC x preg_tag_t  destination preg being allocated
  wr_en  in  NUM_WR  writeback strobe per port
  wr_tag  in  NUM_WR x preg_tag_t  writeback preg
  wr_data  in  NUM_WR x XLEN  writeback data
  flush  in  1  pipeline squash; marks every entry ready
  rd_tag  in  NUM_RD x preg_tag_t  read address
  rd_data  out  NUM_RD x XLEN  read data
  rd_ready  out  NUM_RD  operand-available flag
  wr_collision  out  1  registered pulse: two write ports hit the same tag in one cycle
REQ-007 SHALL use one clock; reset SHALL be asynchronous and active-low (reset_n).

Function
REQ-008 SHALL hold PREGS x XLEN data flops plus a PREGS-bit ready vector.
REQ-009 Preg 0 SHALL be constant zero: writes ignored, reads return 0 with rd_ready=1, and allocation is ignored.
REQ-010 On a write, data SHALL update at the next edge and the ready bit SHALL be set, unless overridden by REQ-012.
REQ-011 When several wr_en ports target the same tag, the lowest-index port SHALL win; wr_collision SHALL be 1 for exactly the following cycle.
REQ-012 On allocation, the ready bit of alloc_tag SHALL be cleared at the next edge; allocation SHALL win over a same-cycle write to that tag (data is still written, ready ends 0).
REQ-013 Flush SHALL set every ready bit to 1 at the next edge; flush SHALL win over same-cycle allocation; same-cycle writes SHALL still update data.
REQ-014 Reads SHALL be combinational with zero-cycle latency. A same-cycle write bypasses to rd_data, with the lowest-index matching wr_en port first, otherwise the stored value.
REQ-015 rd_ready SHALL be the stored ready bit OR'd with any matching same-cycle wr_en; same-cycle alloc and flush SHALL NOT affect rd_ready.
REQ-016 Duplicate alloc_tag values in one cycle SHALL behave as a single allocation.
REQ-017 A write to a tag whose ready bit is already 1 SHALL be accepted without error.

Reset
REQ-018 While reset_n=0: all data SHALL be 0, all ready bits 1, and wr_collision 0; rd_data/rd_ready SHALL reflect this immediately.
REQ-019 Reset asserted mid-operation SHALL discard all pending writes/allocations; the first edge after deassertion SHALL behave normally.

Structure
REQ-020 preg_tag_t, XLEN, and PREGS SHALL come from core_pkg; no new package types are required.
REQ-021 The per-port read/bypass path SHALL be one sub-module, regfile_rd_port, instantiated NUM_RD times by generate.

Verification
REQ-022 Reset, then read tags 0..63 -> all rd_data=0 and rd_ready=1.
REQ-023 Allocate tag 5 -> rd_ready[0]=0 next cycle. Write 0xDEADBEEF to tag 5 on port 1 -> same-cycle rd_data=0xDEADBEEF with rd_ready=1; both persist next cycle.
REQ-024 Write port0 tag 9=0x11 and port1 tag 9=0x22 together -> rd_data=0x11 bypassed, 0x11 stored, and wr_collision=1 for one cycle.
REQ-025 Allocate and write tag 7 (0x55) in the same cycle -> next cycle rd_data=0x55 and rd_ready=0.
REQ-026 Allocate tags 3 and 4, then flush with alloc tag 6 in the same cycle -> next cycle tags 3, 4, and 6 all have rd_ready=1.
REQ-027 Write 0xFF to tag 0 -> rd_data stays 0; assert reset_n=0 mid-write to tag 10 -> tag 10 reads 0 after release.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core-wide widths and the physical-register tag type.
package core_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned PREGS      = 64;
  localparam int unsigned PREG_TAG_W = $clog2(PREGS);

  typedef logic [PREG_TAG_W-1:0] preg_tag_t;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: stored value with same-cycle writeback bypass.
module regfile_rd_port #(
  parameter int unsigned XLEN   = core_pkg::XLEN,
  parameter int unsigned NUM_WR = 2
) (
  input  core_pkg::preg_tag_t                   rd_tag,
  input  logic [NUM_WR-1:0]                     wr_en,
  input  core_pkg::preg_tag_t [NUM_WR-1:0]      wr_tag,
  input  logic [NUM_WR-1:0][XLEN-1:0]           wr_data,
  input  logic [XLEN-1:0]                       stored_data,
  input  logic                                  stored_ready,
  output logic [XLEN-1:0]                       rd_data,
  output logic                                  rd_ready
);

  // Scan from the highest port down so the lowest matching port wins.
  always_comb begin
    rd_data  = stored_data;
    rd_ready = stored_ready;
    for (int w = int'(NUM_WR) - 1; w >= 0; w--) begin
      if (wr_en[w] && (wr_tag[w] == rd_tag)) begin
        rd_data  = wr_data[w];
        rd_ready = 1'b1;
      end
    end
    if (rd_tag == '0) begin
      rd_data  = '0;
      rd_ready = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported physical register file with per-entry ready (scoreboard) bits.
module regfile_mp #(
  parameter int unsigned XLEN      = core_pkg::XLEN,
  parameter int unsigned PREGS     = core_pkg::PREGS,
  parameter int unsigned NUM_WR    = 2,
  parameter int unsigned NUM_RD    = 4,
  parameter int unsigned NUM_ALLOC = 2
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [NUM_ALLOC-1:0]                  alloc_valid,
  input  core_pkg::preg_tag_t [NUM_ALLOC-1:0]   alloc_tag,
  input  logic [NUM_WR-1:0]                     wr_en,
  input  core_pkg::preg_tag_t [NUM_WR-1:0]      wr_tag,
  input  logic [NUM_WR-1:0][XLEN-1:0]           wr_data,
  input  logic                                  flush,
  input  core_pkg::preg_tag_t [NUM_RD-1:0]      rd_tag,
  output logic [NUM_RD-1:0][XLEN-1:0]           rd_data,
  output logic [NUM_RD-1:0]                     rd_ready,
  output logic                                  wr_collision
);

  logic [XLEN-1:0]   r_data [PREGS];
  logic [PREGS-1:0]  r_ready;
  logic [PREGS-1:0]  w_ready_nxt;
  logic              w_collision;
  logic [NUM_WR-1:0] w_wr_en_byp;

  // Ready update priority: write sets, allocation clears, flush sets all.
  always_comb begin
    w_ready_nxt = r_ready;
    for (int unsigned w = 0; w < NUM_WR; w++) begin
      if (wr_en[w] && (wr_tag[w] != '0)) w_ready_nxt[wr_tag[w]] = 1'b1;
    end
    for (int unsigned a = 0; a < NUM_ALLOC; a++) begin
      if (alloc_valid[a] && (alloc_tag[a] != '0)) w_ready_nxt[alloc_tag[a]] = 1'b0;
    end
    if (flush) w_ready_nxt = '1;
    w_ready_nxt[0] = 1'b1;
  end

  always_comb begin
    w_collision = 1'b0;
    for (int unsigned i = 0; i < NUM_WR; i++) begin
      for (int unsigned j = i + 1; j < NUM_WR; j++) begin
        if (wr_en[i] && wr_en[j] && (wr_tag[i] == wr_tag[j])) w_collision = 1'b1;
      end
    end
  end

  // Later NBA wins, so iterate high-to-low to give the lowest port priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned p = 0; p < PREGS; p++) r_data[p] <= '0;
      r_ready      <= '1;
      wr_collision <= 1'b0;
    end else begin
      for (int w = int'(NUM_WR) - 1; w >= 0; w--) begin
        if (wr_en[w] && (wr_tag[w] != '0)) r_data[wr_tag[w]] <= wr_data[w];
      end
      r_ready      <= w_ready_nxt;
      wr_collision <= w_collision;
    end
  end

  // Suppress bypass while in reset so reads show the cleared state at once.
  assign w_wr_en_byp = wr_en & {NUM_WR{reset_n}};

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    regfile_rd_port #(
      .XLEN   (XLEN),
      .NUM_WR (NUM_WR)
    ) u_rd_port (
      .rd_tag       (rd_tag[r]),
      .wr_en        (w_wr_en_byp),
      .wr_tag       (wr_tag),
      .wr_data      (wr_data),
      .stored_data  (r_data[rd_tag[r]]),
      .stored_ready (r_ready[rd_tag[r]]),
      .rd_data      (rd_data[r]),
      .rd_ready     (rd_ready[r])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed scoreboard bench for regfile_mp.
module tb_regfile_mp;

  logic                               clk = 1'b0;
  logic                               reset_n;
  logic [1:0]                         alloc_valid;
  core_pkg::preg_tag_t [1:0]          alloc_tag;
  logic [1:0]                         wr_en;
  core_pkg::preg_tag_t [1:0]          wr_tag;
  logic [1:0][31:0]                   wr_data;
  logic                               flush;
  core_pkg::preg_tag_t [3:0]          rd_tag;
  logic [3:0][31:0]                   rd_data;
  logic [3:0]                         rd_ready;
  logic                               wr_collision;

  typedef struct {
    string       name;
    int          port;
    logic [31:0] data;
    logic        ready;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  regfile_mp dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .alloc_valid  (alloc_valid),
    .alloc_tag    (alloc_tag),
    .wr_en        (wr_en),
    .wr_tag       (wr_tag),
    .wr_data      (wr_data),
    .flush        (flush),
    .rd_tag       (rd_tag),
    .rd_data      (rd_data),
    .rd_ready     (rd_ready),
    .wr_collision (wr_collision)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string n, input int p, input logic [31:0] d, input logic r);
    exp_t e;
    e.name  = n;
    e.port  = p;
    e.data  = d;
    e.ready = r;
    sb.push_back(e);
  endtask

  task automatic check_sb();
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_tests++;
      assert (rd_data[e.port] === e.data) else begin
        n_fail++;
        $error("FAIL %s rd_data[%0d]: got %h expected %h", e.name, e.port, rd_data[e.port], e.data);
      end
      n_tests++;
      assert (rd_ready[e.port] === e.ready) else begin
        n_fail++;
        $error("FAIL %s rd_ready[%0d]: got %b expected %b", e.name, e.port, rd_ready[e.port], e.ready);
      end
    end
  endtask

  task automatic check_coll(input string n, input logic exp);
    n_tests++;
    assert (wr_collision === exp) else begin
      n_fail++;
      $error("FAIL %s wr_collision: got %b expected %b", n, wr_collision, exp);
    end
  endtask

  task automatic idle();
    alloc_valid = '0;
    alloc_tag   = '0;
    wr_en       = '0;
    wr_tag      = '0;
    wr_data     = '0;
    flush       = 1'b0;
  endtask

  initial begin
    idle();
    rd_tag  = '0;
    reset_n = 1'b0;
    tick();
    tick();
    check_coll("reset", 1'b0);
    for (int k = 0; k < 4; k++) begin
      rd_tag[k] = 6'(k + 20);
      push("in_reset", k, 32'h0, 1'b1);
    end
    check_sb();
    reset_n = 1'b1;
    tick();

    for (int t = 0; t < 64; t += 4) begin
      for (int k = 0; k < 4; k++) begin
        rd_tag[k] = 6'(t + k);
        push("reset_sweep", k, 32'h0, 1'b1);
      end
      check_sb();
    end

    // Allocate tag 5: no same-cycle effect on rd_ready, cleared next cycle.
    rd_tag = '0;
    rd_tag[0] = 6'd5;
    alloc_valid[0] = 1'b1; alloc_tag[0] = 6'd5;
    push("alloc5_same", 0, 32'h0, 1'b1);
    check_sb();
    tick();
    idle();
    push("alloc5_next", 0, 32'h0, 1'b0);
    check_sb();

    wr_en[1] = 1'b1; wr_tag[1] = 6'd5; wr_data[1] = 32'hDEADBEEF;
    push("wr5_bypass", 0, 32'hDEADBEEF, 1'b1);
    check_sb();
    tick();
    idle();
    push("wr5_stored", 0, 32'hDEADBEEF, 1'b1);
    check_sb();

    // Two ports to tag 9: port 0 wins, collision pulse for one cycle.
    rd_tag[0] = 6'd9;
    wr_en = 2'b11; wr_tag[0] = 6'd9; wr_tag[1] = 6'd9;
    wr_data[0] = 32'h11; wr_data[1] = 32'h22;
    push("coll_bypass", 0, 32'h11, 1'b1);
    check_sb();
    tick();
    idle();
    check_coll("coll_pulse", 1'b1);
    push("coll_stored", 0, 32'h11, 1'b1);
    check_sb();
    tick();
    check_coll("coll_clear", 1'b0);

    // Allocate and write tag 7 together: data lands, ready ends 0.
    rd_tag[0] = 6'd7;
    alloc_valid[1] = 1'b1; alloc_tag[1] = 6'd7;
    wr_en[0] = 1'b1; wr_tag[0] = 6'd7; wr_data[0] = 32'h55;
    tick();
    idle();
    push("alloc_wr7", 0, 32'h55, 1'b0);
    check_sb();

    rd_tag[0] = 6'd3; rd_tag[1] = 6'd4; rd_tag[2] = 6'd6;
    alloc_valid = 2'b11; alloc_tag[0] = 6'd3; alloc_tag[1] = 6'd4;
    tick();
    idle();
    push("alloc3", 0, 32'h0, 1'b0);
    push("alloc4", 1, 32'h0, 1'b0);
    push("pre6", 2, 32'h0, 1'b1);
    check_sb();
    flush = 1'b1;
    alloc_valid[0] = 1'b1; alloc_tag[0] = 6'd6;
    tick();
    idle();
    push("flush3", 0, 32'h0, 1'b1);
    push("flush4", 1, 32'h0, 1'b1);
    push("flush6", 2, 32'h0, 1'b1);
    check_sb();

    // Duplicate allocation, then a single write restores readiness.
    rd_tag[0] = 6'd8;
    alloc_valid = 2'b11; alloc_tag[0] = 6'd8; alloc_tag[1] = 6'd8;
    tick();
    idle();
    push("dup_alloc8", 0, 32'h0, 1'b0);
    check_sb();
    wr_en[0] = 1'b1; wr_tag[0] = 6'd8; wr_data[0] = 32'hA5A5_0008;
    tick();
    idle();
    push("wr8", 0, 32'hA5A5_0008, 1'b1);
    check_sb();
    wr_en[1] = 1'b1; wr_tag[1] = 6'd8; wr_data[1] = 32'h0000_1234;
    tick();
    idle();
    push("wr8_ready", 0, 32'h0000_1234, 1'b1);
    check_sb();

    // Preg 0 ignores writes and allocation.
    rd_tag[0] = 6'd0;
    wr_en[0] = 1'b1; wr_tag[0] = 6'd0; wr_data[0] = 32'hFF;
    alloc_valid[1] = 1'b1; alloc_tag[1] = 6'd0;
    push("p0_bypass", 0, 32'h0, 1'b1);
    check_sb();
    tick();
    idle();
    push("p0_stored", 0, 32'h0, 1'b1);
    check_sb();

    // Reset asserted while a write to tag 10 is pending.
    rd_tag[0] = 6'd10; rd_tag[1] = 6'd5; rd_tag[2] = 6'd7;
    wr_en[0] = 1'b1; wr_tag[0] = 6'd10; wr_data[0] = 32'hAB;
    #1;
    reset_n = 1'b0;
    push("rst_mid10", 0, 32'h0, 1'b1);
    push("rst_mid5", 1, 32'h0, 1'b1);
    check_sb();
    tick();
    reset_n = 1'b1;
    idle();
    push("rst_tag10", 0, 32'h0, 1'b1);
    push("rst_tag5", 1, 32'h0, 1'b1);
    push("rst_tag7", 2, 32'h0, 1'b1);
    check_sb();
    check_coll("rst_coll", 1'b0);

    rd_tag[0] = 6'd11;
    wr_en[0] = 1'b1; wr_tag[0] = 6'd11; wr_data[0] = 32'h77;
    tick();
    idle();
    push("post_rst_wr", 0, 32'h77, 1'b1);
    check_sb();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
